alu_mdu: RTL and testbench

Parametrised multi-cycle execute unit for the single-cycle core's next revision. It covers all RV32I register ALU operations and the RV32M multiply/divide group behind one valid/ready handshake. Base ops take one cycle; multiply and divide use an iterative datapath that is XLEN cycles long. It sits between decode and writeback and stalls the pipeline through `in_ready`/`out_valid`.

---
 rtl/alu_mdu.sv | 157 +++++++++++++++
 tb/tb_alu_mdu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// RV32I register ALU plus RV32M multiply/divide behind a valid/ready handshake.
// Base ops finish at the accept edge; MUL/DIV iterate one bit per cycle for XLEN cycles.
module alu_mdu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [4:0]      ALU_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag
);

  localparam int unsigned     W2       = 2 * XLEN;
  localparam logic [SHW-1:0]  LastIter = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic [1:0]      op_q;
  logic [W2-1:0]   acc_q;
  logic [XLEN-1:0] opb_q;
  logic            neg_q;
  logic [SHW-1:0]  cnt_q;

  logic            is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, div_special, neg_d;
  logic [XLEN-1:0] a_mag, b_mag, base_res, quick_res;
  logic [SHW-1:0]  shamt;

  always_comb begin
    is_mul      = (ALU_sel[4:2] == 3'b100);
    is_div      = (ALU_sel[4:2] == 3'b101);
    a_sgn       = (is_mul && (ALU_sel[1:0] == 2'd1 || ALU_sel[1:0] == 2'd2)) ||
                  (is_div && !ALU_sel[0]);
    b_sgn       = (is_mul && ALU_sel[1:0] == 2'd1) || (is_div && !ALU_sel[0]);
    a_neg       = a_sgn & srcA[XLEN-1];
    b_neg       = b_sgn & srcB[XLEN-1];
    a_mag       = a_neg ? -srcA : srcA;
    b_mag       = b_neg ? -srcB : srcB;
    div_zero    = (srcB == '0);
    div_ovf     = !ALU_sel[0] && (srcA == MinNeg) && (srcB == '1);
    div_special = is_div && (div_zero || div_ovf);
    // Remainder follows the dividend's sign; quotient and products follow sign(A)^sign(B).
    neg_d       = (is_div && ALU_sel[1]) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    shamt    = srcB[SHW-1:0];
    base_res = '0;
    case (ALU_sel)
      5'd0:    base_res = srcA + srcB;
      5'd1:    base_res = srcA - srcB;
      5'd2:    base_res = srcA & srcB;
      5'd3:    base_res = srcA | srcB;
      5'd4:    base_res = srcA ^ srcB;
      5'd5:    base_res = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      5'd6:    base_res = {{(XLEN-1){1'b0}}, srcA < srcB};
      5'd7:    base_res = srcA << shamt;
      5'd8:    base_res = srcA >> shamt;
      5'd9:    base_res = $unsigned($signed(srcA) >>> shamt);
      default: base_res = '0;
    endcase
    quick_res = base_res;
    if (is_div) begin
      if (div_zero) quick_res = ALU_sel[1] ? srcA : '1;
      else          quick_res = ALU_sel[1] ? '0 : srcA;
    end
  end

  logic [XLEN:0]   mul_sum, div_tmp, div_diff;
  logic            div_ge;
  logic [W2-1:0]   mul_next, div_next, mul_full;
  logic [XLEN-1:0] div_sel, fin_res;

  // acc_q: multiply keeps {partial product, remaining multiplier};
  // divide keeps {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_tmp  = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    div_ge   = (div_tmp >= {1'b0, opb_q});
    div_diff = div_tmp - {1'b0, opb_q};
    div_next = {div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    mul_full = neg_q ? -mul_next : mul_next;
    div_sel  = op_q[1] ? div_next[W2-1:XLEN] : div_next[XLEN-1:0];
    if (state_q == StMul) begin
      fin_res = (op_q == 2'd0) ? mul_full[XLEN-1:0] : mul_full[W2-1:XLEN];
    end else begin
      fin_res = neg_q ? -div_sel : div_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q  <= ALU_sel[1:0];
            neg_q <= neg_d;
            cnt_q <= '0;
            if (is_mul) begin
              acc_q   <= {{XLEN{1'b0}}, b_mag};
              opb_q   <= a_mag;
              state_q <= StMul;
            end else if (is_div && !div_special) begin
              acc_q   <= {{XLEN{1'b0}}, a_mag};
              opb_q   <= b_mag;
              state_q <= StDiv;
            end else begin
              result_q <= quick_res;
              zero_q   <= (quick_res == '0);
              state_q  <= StDone;
            end
          end
        end
        StMul, StDiv: begin
          acc_q <= (state_q == StMul) ? mul_next : div_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            result_q <= fin_res;
            zero_q   <= (fin_res == '0);
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: arithmetic reference model plus cycle-level handshake model,
// directed corner cases, reset mid-iteration, an XLEN=8 instance and random traffic.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero_flag;
  logic [31:0] srcA, srcB, result;
  logic [4:0]  ALU_sel;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
  logic [7:0]  srcA8, srcB8, result8;
  logic [4:0]  sel8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB), .ALU_sel(ALU_sel), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero_flag(zero_flag)
  );

  alu_mdu #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .srcA(srcA8), .srcB(srcB8), .ALU_sel(sel8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .zero_flag(zero8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on w-bit operands using wide signed integers.
  function automatic logic [63:0] model(input int unsigned w, input logic [4:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] one, mask, ua, ub, sa, sb, r;
    int unsigned sh;
    one  = 128'sd1;
    mask = (one << w) - one;
    ua   = $signed({64'h0, a}) & mask;
    ub   = $signed({64'h0, b}) & mask;
    sa   = ua[w-1] ? ua - (one << w) : ua;
    sb   = ub[w-1] ? ub - (one << w) : ub;
    sh   = 32'(b) & (w - 1);
    case (op)
      5'd0:    r = ua + ub;
      5'd1:    r = ua - ub;
      5'd2:    r = ua & ub;
      5'd3:    r = ua | ub;
      5'd4:    r = ua ^ ub;
      5'd5:    r = (sa < sb) ? one : 128'sd0;
      5'd6:    r = (ua < ub) ? one : 128'sd0;
      5'd7:    r = ua << sh;
      5'd8:    r = ua >> sh;
      5'd9:    r = sa >>> sh;
      5'd16:   r = ua * ub;
      5'd17:   r = (sa * sb) >>> w;
      5'd18:   r = (sa * ub) >>> w;
      5'd19:   r = (ua * ub) >> w;
      5'd20:   r = (ub == 0) ? mask : sa / sb;
      5'd21:   r = (ub == 0) ? mask : ua / ub;
      5'd22:   r = (ub == 0) ? ua : sa % sb;
      5'd23:   r = (ub == 0) ? ua : ua % ub;
      default: r = 128'sd0;
    endcase
    r = r & mask;
    return r[63:0];
  endfunction

  // Edges from the accept edge (counted as 1) until out_valid is high.
  function automatic int unsigned lat_of(input int unsigned w, input logic [4:0] op,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, msb;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    if (op >= 5'd16 && op <= 5'd19) return w + 1;
    if (op >= 5'd20 && op <= 5'd23) begin
      if ((b & mask) == 64'd0) return 1;
      if (!op[0] && (a & mask) == msb && (b & mask) == mask) return 1;
      return w + 1;
    end
    return 1;
  endfunction

  // Handshake model of the 32-bit instance.
  logic        m_busy;
  int unsigned m_cnt, m_lat;
  logic [31:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_lat  <= lat_of(32, ALU_sel, {32'h0, srcA}, {32'h0, srcB});
        m_exp  <= 32'(model(32, ALU_sel, {32'h0, srcA}, {32'h0, srcB}));
      end
    end else if (m_cnt >= m_lat) begin
      if (out_ready) m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("in_ready", {63'h0, in_ready}, {63'h0, !m_busy});
      chk("out_valid", {63'h0, out_valid}, {63'h0, m_busy && m_cnt >= m_lat});
      if (m_busy && m_cnt >= m_lat) begin
        chk("result", {32'h0, result}, {32'h0, m_exp});
        chk("zero_flag", {63'h0, zero_flag}, {63'h0, m_exp == 32'h0});
      end
    end
  end

  function automatic logic [31:0] rnd_val();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rnd_op();
    logic [4:0] ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                              5'd12, 5'd27};
    return ops[$urandom % 20];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (m_busy && n < 200) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("idle before request", {63'h0, m_busy}, 64'h0);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int unsigned lat,
                        input bit bp, input bit noise);
    int n;
    chk({name, " model"}, model(32, op, {32'h0, a}, {32'h0, b}), {32'h0, exp});
    wait_idle();
    in_valid = 1'b1;
    ALU_sel  = op;
    srcA     = a;
    srcB     = b;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = noise ? 1'($urandom % 2) : 1'b0;
      if (noise) begin
        ALU_sel = rnd_op();
        srcA    = $urandom;
        srcB    = $urandom;
      end
    end while (!out_valid && n < 100);
    in_valid = 1'b0;
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, {32'h0, result}, {32'h0, exp});
    chk({name, " zero"}, {63'h0, zero_flag}, {63'h0, exp == 32'h0});
    if (bp) begin
      repeat (10) begin
        @(negedge clk);
        chk({name, " held result"}, {32'h0, result}, {32'h0, exp});
        chk({name, " held in_ready"}, {63'h0, in_ready}, 64'h0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, " consumed out_valid"}, {63'h0, out_valid}, 64'h0);
    chk({name, " consumed in_ready"}, {63'h0, in_ready}, 64'h1);
  endtask

  task automatic run8(input string name, input logic [4:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp, input int unsigned lat);
    int n;
    chk({name, " model"}, model(8, op, {56'h0, a}, {56'h0, b}), {56'h0, exp});
    @(negedge clk);
    in_valid8  = 1'b1;
    sel8       = op;
    srcA8      = a;
    srcB8      = b;
    out_ready8 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid8 = 1'b0;
    end while (!out_valid8 && n < 100);
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, {56'h0, result8}, {56'h0, exp});
    chk({name, " zero"}, {63'h0, zero8}, {63'h0, exp == 8'h0});
    out_ready8 = 1'b1;
    @(negedge clk);
    chk({name, " consumed out_valid"}, {63'h0, out_valid8}, 64'h0);
    out_ready8 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; srcA = '0; srcB = '0; ALU_sel = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; srcA8 = '0; srcB8 = '0; sel8 = '0;
    repeat (3) @(negedge clk);
    chk("reset result", {32'h0, result}, 64'h0);
    chk("reset zero_flag", {63'h0, zero_flag}, 64'h0);
    chk("reset out_valid", {63'h0, out_valid}, 64'h0);
    chk("reset in_ready", {63'h0, in_ready}, 64'h1);
    rst_n = 1'b1;

    run_op("sub",      5'd1,  32'd5,          32'd7,          32'hFFFF_FFFE, 1,  0, 0);
    run_op("slt",      5'd5,  32'h8000_0000,  32'd1,          32'd1,         1,  0, 0);
    run_op("sra",      5'd9,  32'h8000_0000,  32'd31,         32'hFFFF_FFFF, 1,  0, 0);
    run_op("xor",      5'd4,  32'hA5A5_A5A5,  32'hA5A5_A5A5,  32'd0,         1,  1, 0);
    run_op("reserved", 5'd12, 32'd5,          32'd6,          32'd0,         1,  0, 0);
    run_op("mul",      5'd16, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         33, 0, 0);
    run_op("mulh",     5'd17, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33, 0, 0);
    run_op("mulhsu",   5'd18, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 0, 0);
    run_op("mulhu",    5'd19, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33, 0, 0);
    run_op("div",      5'd20, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33, 0, 0);
    run_op("rem",      5'd22, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33, 0, 0);
    run_op("divu",     5'd21, 32'd100,        32'd7,          32'd14,        33, 1, 1);
    run_op("remu",     5'd23, 32'd100,        32'd7,          32'd2,         33, 0, 0);
    run_op("rem0",     5'd22, 32'h1234,       32'd0,          32'h1234,      1,  0, 0);
    run_op("divovf",   5'd20, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1,  0, 0);
    run_op("removf",   5'd22, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1,  0, 0);
    run_op("divu0",    5'd21, 32'h1234,       32'd0,          32'hFFFF_FFFF, 1,  0, 0);

    // Reset pulse partway through a multiply.
    wait_idle();
    in_valid = 1'b1; ALU_sel = 5'd16; srcA = 32'h1234_5678; srcB = 32'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset result", {32'h0, result}, 64'h0);
    chk("midreset zero_flag", {63'h0, zero_flag}, 64'h0);
    chk("midreset out_valid", {63'h0, out_valid}, 64'h0);
    chk("midreset in_ready", {63'h0, in_ready}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add after reset", 5'd0, 32'd2, 32'd3, 32'd5, 1, 0, 0);

    run8("mulh8",  5'd17, 8'h80, 8'h80, 8'h40, 9);
    run8("div8",   5'd20, 8'hF9, 8'h02, 8'hFD, 9);
    run8("removf8", 5'd22, 8'h80, 8'hFF, 8'h00, 1);
    run8("add8",   5'd0,  8'hF0, 8'h20, 8'h10, 1);

    // Random traffic; every cycle is checked against the handshake model.
    repeat (4000) begin
      @(negedge clk);
      in_valid  = ($urandom % 3) != 0;
      ALU_sel   = rnd_op();
      srcA      = rnd_val();
      srcB      = rnd_val();
      out_ready = ($urandom % 4) != 0;
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
